// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the RSA mod-exp engine arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    // Message/result width of the mod-exp engine.
    localparam int DEFAULT_WIDTH = 256;

    // Engine encrypt_decrypt encoding.
    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    // Arbiter job FSM, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether the grant is used.
// Ports: req (request vector), ptr (last served index), gnt (one-hot), idx (binary grant), any (some request set).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        // Offset 1..NREQ from the pointer; the last served requester is checked last.
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IW'(cand);
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rsa_modexp_arbiter.sv
// Shares one RSA mod-exp engine among NREQ requesters, one job in flight, round-robin grant.
// Latency: accept at T, eng_start at T+1, response the cycle after engine done (or after TIMEOUT wait cycles).
// Backpressure: req_ready only in IDLE; response held on rsp_valid[g] until rsp_ready[g].
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_mode/req_msg job intake;
//        rsp_valid/rsp_ready/rsp_msg/rsp_err response; eng_start/eng_mode/eng_msg/eng_done/eng_result
//        engine side; busy high outside IDLE.
module rsa_modexp_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*WIDTH-1:0] req_msg,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_msg,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic                  eng_mode,
    output logic [WIDTH-1:0]      eng_msg,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int IW = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     arb_idx;
    logic [NREQ-1:0]   arb_gnt;
    logic              arb_any;
    logic [CW-1:0]     tmo_cnt;
    logic              timed_out;
    logic [WIDTH-1:0]  msg_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign msg_arr[gi] = req_msg[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req  (req_valid),
        .ptr  (ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign timed_out = (tmo_cnt == CNT_LAST);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Any eng_done seen here belongs to a previous job and is ignored.
                eng_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[gidx] = 1'b1;
                if (rsp_ready[gidx]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= IW'(NREQ - 1);
            gidx     <= '0;
            tmo_cnt  <= '0;
            eng_msg  <= '0;
            eng_mode <= MODE_DEC;
            rsp_msg  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gidx     <= arb_idx;
                        eng_msg  <= msg_arr[arb_idx];
                        eng_mode <= req_mode[arb_idx];
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (eng_done) begin
                        rsp_msg <= eng_result;
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_msg <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // Pointer moves only once the job is fully delivered.
                    if (rsp_ready[gidx]) begin
                        ptr <= gidx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Bench for rsa_modexp_arbiter with a stub engine (done N cycles after start, result = msg+1).
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low on the granted requester.
module tb_rsa_modexp_arbiter;
    import rsa_pkg::*;

    localparam int WIDTH   = 256;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_mode = 4'b0101;
    logic [NREQ*WIDTH-1:0] req_msg = '0;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '0;
    logic [WIDTH-1:0]      rsp_msg;
    logic                  rsp_err;
    logic                  eng_start;
    logic                  eng_mode;
    logic [WIDTH-1:0]      eng_msg;
    logic                  eng_done = 1'b0;
    logic [WIDTH-1:0]      eng_result;
    logic                  busy;

    rsa_modexp_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_msg    (req_msg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_msg    (rsp_msg),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_mode   (eng_mode),
        .eng_msg    (eng_msg),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Stub engine: eng_done is high for the cycle stub_lat cycles after the start cycle;
    // stub_lat = 0 never finishes; spur_issue raises a stale done in the start cycle itself.
    int               stub_lat = 0;
    int               stub_cnt = 0;
    logic             spur_issue = 1'b0;
    logic [WIDTH-1:0] stub_res = '0;

    always @(negedge clk) begin
        eng_done = 1'b0;
        if (eng_start) begin
            stub_cnt = stub_lat;
            stub_res = eng_msg + 1;
            eng_done = spur_issue;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) eng_done = 1'b1;
        end
    end
    assign eng_result = stub_res;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] msg;
        logic             err;
    } exp_t;

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] mask;
        int              lat;
        logic            spur;
        int              hold;
        int              exp_idx;
        int              exp_ofs;
        logic            exp_err;
    } job_t;

    exp_t sb_q[$];
    job_t jobs[10];
    job_t hj;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_msg();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < WIDTH/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        rsp_ready  = '0;
        stub_lat   = 0;
        spur_issue = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic run_job(input job_t j);
        int               t;
        int               idx;
        int               acc;
        logic [NREQ-1:0]  oh;
        logic [WIDTH-1:0] in_msg;
        exp_t             e;
        if (j.rst) do_reset();
        rsp_ready  = '1;
        stub_lat   = j.lat;
        spur_issue = j.spur;
        req_valid  = j.mask;
        #1;
        t = 0;
        while (req_ready == '0 && t < 40) begin
            step();
            t++;
        end
        if (req_ready == '0) begin
            chk("accept_seen", '0, 256'(1));
            return;
        end
        oh  = req_ready;
        idx = 0;
        for (int k = 0; k < NREQ; k++) if (oh[k]) idx = k;
        chk("grant", 256'(oh), 256'(NREQ'(1) << j.exp_idx));
        chk("accept_no_start", 256'(eng_start), '0);
        chk("accept_not_busy", 256'(busy), '0);
        acc    = cyc;
        in_msg = req_msg[idx*WIDTH +: WIDTH];
        e.idx  = idx;
        e.err  = (j.lat == 0);
        e.msg  = e.err ? '0 : in_msg + 1;
        sb_q.push_back(e);

        step();
        chk("start_pulse", 256'(eng_start), 256'(1));
        chk("eng_msg", eng_msg, in_msg);
        chk("eng_mode", 256'(eng_mode), 256'(req_mode[idx]));
        chk("issue_no_accept", 256'(req_ready), '0);
        chk("issue_busy", 256'(busy), 256'(1));
        // New data on the port must not disturb the latched job.
        req_msg[idx*WIDTH +: WIDTH] = rand_msg();

        step();
        t = 0;
        while (rsp_valid == '0 && t < 40) begin
            chk("wait_no_start", 256'(eng_start), '0);
            chk("wait_no_accept", 256'(req_ready), '0);
            chk("wait_msg_held", eng_msg, in_msg);
            step();
            t++;
        end
        if (rsp_valid == '0) begin
            chk("rsp_seen", '0, 256'(1));
            return;
        end
        chk("rsp_latency", 256'(cyc - acc), 256'(j.exp_ofs));
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", '0, 256'(1));
            return;
        end
        e = sb_q.pop_front();
        chk("rsp_onehot", 256'(rsp_valid), 256'(NREQ'(1) << e.idx));
        chk("rsp_msg", rsp_msg, e.msg);
        chk("rsp_err", 256'(rsp_err), 256'(j.exp_err));
        if (j.hold > 0) begin
            rsp_ready = ~(NREQ'(1) << idx);
            for (int k = 0; k < j.hold; k++) begin
                step();
                chk("hold_valid", 256'(rsp_valid), 256'(NREQ'(1) << e.idx));
                chk("hold_msg", rsp_msg, e.msg);
                chk("hold_no_accept", 256'(req_ready), '0);
                chk("hold_no_start", 256'(eng_start), '0);
            end
            rsp_ready = '1;
        end
        step();
        chk("rsp_cleared", 256'(rsp_valid), '0);
        chk("idle_after_rsp", 256'(busy), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   mask     lat spur hold idx ofs err
        jobs[0] = '{1'b0, 4'b0001, 5, 1'b0, 0,  0, 7,  1'b0};
        jobs[1] = '{1'b1, 4'b1111, 2, 1'b0, 0,  0, 4,  1'b0};
        jobs[2] = '{1'b0, 4'b1111, 3, 1'b0, 0,  1, 5,  1'b0};
        jobs[3] = '{1'b0, 4'b1111, 2, 1'b0, 0,  2, 4,  1'b0};
        jobs[4] = '{1'b0, 4'b1111, 4, 1'b0, 0,  3, 6,  1'b0};
        jobs[5] = '{1'b0, 4'b0101, 2, 1'b0, 0,  0, 4,  1'b0};
        jobs[6] = '{1'b0, 4'b0101, 2, 1'b0, 0,  2, 4,  1'b0};
        jobs[7] = '{1'b0, 4'b0010, 3, 1'b0, 10, 1, 5,  1'b0};
        jobs[8] = '{1'b0, 4'b1000, 0, 1'b0, 0,  3, 18, 1'b1};
        jobs[9] = '{1'b0, 4'b1000, 2, 1'b0, 0,  3, 4,  1'b0};

        req_msg[0*WIDTH +: WIDTH] = 256'h48656c6c6f20576f726c6421;
        for (int k = 1; k < NREQ; k++) req_msg[k*WIDTH +: WIDTH] = rand_msg();

        do_reset();
        chk("rst_req_ready", 256'(req_ready), '0);
        chk("rst_rsp_valid", 256'(rsp_valid), '0);
        chk("rst_rsp_err", 256'(rsp_err), '0);
        chk("rst_eng_start", 256'(eng_start), '0);
        chk("rst_busy", 256'(busy), '0);
        chk("rst_eng_msg", eng_msg, '0);
        chk("rst_rsp_msg", rsp_msg, '0);
        chk("rst_eng_mode", 256'(eng_mode), '0);
        chk("req0_is_encrypt", 256'(req_mode[0]), 256'(MODE_ENC));

        for (int i = 0; i < 10; i++) run_job(jobs[i]);

        // Reset while the engine is running: job abandoned, late done ignored.
        req_valid  = 4'b0001;
        rsp_ready  = '1;
        stub_lat   = 8;
        spur_issue = 1'b0;
        #1;
        chk("t5_accept", 256'(req_ready), 256'(4'b0001));
        step();
        step();
        step();
        chk("t5_in_wait", 256'(busy), 256'(1));
        reset     = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        sb_q.delete();
        chk("t5_req_ready", 256'(req_ready), '0);
        chk("t5_rsp_valid", 256'(rsp_valid), '0);
        chk("t5_rsp_err", 256'(rsp_err), '0);
        chk("t5_eng_start", 256'(eng_start), '0);
        chk("t5_busy", 256'(busy), '0);
        chk("t5_eng_msg", eng_msg, '0);
        chk("t5_rsp_msg", rsp_msg, '0);
        chk("t5_eng_mode", 256'(eng_mode), '0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t5_late_done_rsp", 256'(rsp_valid), '0);
            chk("t5_late_done_busy", 256'(busy), '0);
        end
        hj = '{1'b0, 4'b0100, 2, 1'b0, 0, 2, 4, 1'b0};
        run_job(hj);

        // Stale done during the start cycle, real done three cycles later.
        hj = '{1'b0, 4'b0001, 3, 1'b1, 0, 0, 5, 1'b0};
        run_job(hj);

        req_valid = '0;
        step();
        chk("sb_drained", 256'(sb_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
